// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// sizing rule for its bit counter.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Enough bits to count 0..width-1, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fa.sv
// Combinational one-bit full adder; the arithmetic slice of the serial adder.
module fa (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic s_out,
    output logic c_out
);

    assign s_out = a_in ^ b_in ^ c_in;
    assign c_out = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: {c_out, s_out} = a + b + c_in over WIDTH clocks
// through a single full-adder slice, with a start/busy/done handshake.
module serial_adder
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c;

    fa u_fa (
        .a_in  (a_q[0]),
        .b_in  (b_q[0]),
        .c_in  (carry_q),
        .s_out (fa_s),
        .c_out (fa_c)
    );

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path
        // through the case statement can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = c_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    cnt_d   = cnt_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the whole datapath, not just the FSM, is cleared on reset so a
    // start after reset behaves exactly like one after power-up.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_out = (state_q == SHIFT);
    assign done_out = (state_q == DONE);
    assign s_out    = sum_q;
    assign c_out    = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 2 and 32 against an
// arithmetic reference {c,s} = a + b + cin.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    logic       start8, cin8, busy8, done8, c8;
    logic [7:0] a8, b8, s8;
    logic       start2, cin2, busy2, done2, c2;
    logic [1:0] a2, b2, s2;
    logic        start32, cin32, busy32, done32, c32;
    logic [31:0] a32, b32, s32;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] prev_s [3];
    logic        prev_c [3];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk_in(clk), .rst_in(rst), .start_in(start8), .a_in(a8), .b_in(b8), .c_in(cin8),
        .busy_out(busy8), .done_out(done8), .s_out(s8), .c_out(c8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk_in(clk), .rst_in(rst), .start_in(start2), .a_in(a2), .b_in(b2), .c_in(cin2),
        .busy_out(busy2), .done_out(done2), .s_out(s2), .c_out(c2)
    );

    serial_adder #(.WIDTH(32)) dut32 (
        .clk_in(clk), .rst_in(rst), .start_in(start32), .a_in(a32), .b_in(b32), .c_in(cin32),
        .busy_out(busy32), .done_out(done32), .s_out(s32), .c_out(c32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input int w);
        return (w == 8) ? 0 : ((w == 2) ? 1 : 2);
    endfunction

    task automatic set_inputs(input int w, input logic st, input logic [31:0] a,
                              input logic [31:0] b, input logic ci);
        case (w)
            2: begin start2 = st; a2 = a[1:0]; b2 = b[1:0]; cin2 = ci; end
            32: begin start32 = st; a32 = a; b32 = b; cin32 = ci; end
            default: begin start8 = st; a8 = a[7:0]; b8 = b[7:0]; cin8 = ci; end
        endcase
    endtask

    task automatic observe(input int w, output logic bsy, output logic dn,
                           output logic [31:0] s, output logic c);
        case (w)
            2: begin bsy = busy2; dn = done2; s = {30'b0, s2}; c = c2; end
            32: begin bsy = busy32; dn = done32; s = s32; c = c32; end
            default: begin bsy = busy8; dn = done8; s = {24'b0, s8}; c = c8; end
        endcase
    endtask

    task automatic clear_prev();
        for (int i = 0; i < 3; i++) begin
            prev_s[i] = '0;
            prev_c[i] = 1'b0;
        end
    endtask

    // One complete add: checks busy length, done pulse, result, and that the
    // previous result stays on s_out/c_out while the add is in progress.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input string tag);
        logic [63:0] mask, full;
        logic [31:0] exp_s, obs_s;
        logic        exp_c, obs_c, obs_busy, obs_done;
        int          n, k;
        mask  = (64'd1 << w) - 64'd1;
        full  = ({32'b0, a} & mask) + ({32'b0, b} & mask) + {63'b0, ci};
        exp_s = 32'(full & mask);
        exp_c = full[w];
        k     = idx_of(w);

        set_inputs(w, 1'b1, a, b, ci);
        tick();
        set_inputs(w, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
        observe(w, obs_busy, obs_done, obs_s, obs_c);
        n = 0;
        while (obs_busy === 1'b1 && n <= w + 2) begin
            n_vec++;
            if (obs_s !== prev_s[k] || obs_c !== prev_c[k]) begin
                n_err++;
                $display("FAIL %s_hold w=%0d: s_out=%h c_out=%b, required held %h/%b",
                         tag, w, obs_s, obs_c, prev_s[k], prev_c[k]);
            end
            n++;
            tick();
            observe(w, obs_busy, obs_done, obs_s, obs_c);
        end
        n_vec++;
        if (n !== w) begin
            n_err++;
            $display("FAIL %s_busy_len w=%0d: busy cycles=%0d, required %0d", tag, w, n, w);
        end
        n_vec++;
        if (obs_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_done w=%0d: done_out=%b, required 1", tag, w, obs_done);
        end
        n_vec++;
        if (obs_s !== exp_s || obs_c !== exp_c) begin
            n_err++;
            $display("FAIL %s_sum w=%0d a=%h b=%h cin=%b: got c=%b s=%h, required c=%b s=%h",
                     tag, w, a, b, ci, obs_c, obs_s, exp_c, exp_s);
        end
        tick();
        observe(w, obs_busy, obs_done, obs_s, obs_c);
        n_vec++;
        if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_done_width w=%0d: busy=%b done=%b, required 0/0",
                     tag, w, obs_busy, obs_done);
        end
        prev_s[k] = exp_s;
        prev_c[k] = exp_c;
    endtask

    task automatic test_reset();
        logic [31:0] s;
        logic        bsy, dn, c;
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            int w;
            w = (i == 0) ? 8 : ((i == 1) ? 2 : 32);
            observe(w, bsy, dn, s, c);
            n_vec++;
            if (bsy !== 1'b0 || dn !== 1'b0 || s !== 32'd0 || c !== 1'b0) begin
                n_err++;
                $display("FAIL reset w=%0d: busy=%b done=%b s=%h c=%b, required all zero",
                         w, bsy, dn, s, c);
            end
        end
        rst = 1'b0;
        clear_prev();
        tick();
    endtask

    task automatic test_reset_priority();
        rst = 1'b1;
        set_inputs(8, 1'b1, 32'hFF, 32'hFF, 1'b1);
        tick();
        n_vec++;
        if (busy8 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_vs_start: busy_out=%b, required 0", busy8);
        end
        rst = 1'b0;
        set_inputs(8, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        n_vec++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || s8 !== 8'h00 || c8 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_vs_start_idle: busy=%b done=%b s=%h c=%b, required 0/0/00/0",
                     busy8, done8, s8, c8);
        end
    endtask

    task automatic test_directed();
        run_op(8, 32'h3C, 32'h05, 1'b0, "dir_3c_05");
        run_op(8, 32'hFF, 32'h01, 1'b0, "dir_ff_01");
        run_op(8, 32'hFF, 32'hFF, 1'b1, "dir_ff_ff_c");
        run_op(8, 32'h00, 32'h00, 1'b0, "dir_zero");
    endtask

    // start_in held high: results every WIDTH+2 cycles, operands scrambled mid-add.
    task automatic test_back_to_back();
        int pulses, last_t, waited;
        pulses = 0;
        last_t = -1;
        set_inputs(8, 1'b1, 32'h10, 32'h20, 1'b0);
        for (int cyc = 0; cyc < 36; cyc++) begin
            tick();
            if (busy8 === 1'b1) begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                cin8 = 1'($urandom_range(0, 1));
            end else begin
                a8   = 8'h10;
                b8   = 8'h20;
                cin8 = 1'b0;
            end
            if (done8 === 1'b1) begin
                n_vec++;
                if (s8 !== 8'h30 || c8 !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_sum: got c=%b s=%h, required c=0 s=30", c8, s8);
                end
                if (last_t >= 0) begin
                    n_vec++;
                    if (cyc - last_t !== 10) begin
                        n_err++;
                        $display("FAIL b2b_period: %0d cycles, required 10", cyc - last_t);
                    end
                end
                last_t = cyc;
                pulses++;
            end
        end
        start8 = 1'b0;
        n_vec++;
        if (pulses < 3) begin
            n_err++;
            $display("FAIL b2b_pulses: %0d done pulses, required at least 3", pulses);
        end
        waited = 0;
        while ((busy8 !== 1'b0 || done8 !== 1'b0) && waited < 15) begin
            tick();
            waited++;
        end
        n_vec++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: busy=%b done=%b, required idle", busy8, done8);
        end
        prev_s[0] = 32'h30;
        prev_c[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        set_inputs(8, 1'b1, 32'hAA, 32'h55, 1'b0);
        tick();
        set_inputs(8, 1'b0, 32'hAA, 32'h55, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || s8 !== 8'h00 || c8 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: busy=%b done=%b s=%h c=%b, required 0/0/00/0",
                     busy8, done8, s8, c8);
        end
        clear_prev();
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 !== 1'b0) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_no_done: done_out pulsed after abandoned add, required none");
        end
        run_op(8, 32'h01, 32'h01, 1'b0, "post_rst");
    endtask

    task automatic test_random(input int w, input int count);
        for (int i = 0; i < count; i++) begin
            run_op(w, $urandom, $urandom, 1'($urandom_range(0, 1)), "rand");
        end
    endtask

    initial begin
        rst = 1'b1;
        set_inputs(8, 1'b0, 32'h0, 32'h0, 1'b0);
        set_inputs(2, 1'b0, 32'h0, 32'h0, 1'b0);
        set_inputs(32, 1'b0, 32'h0, 32'h0, 1'b0);
        clear_prev();

        test_reset();
        test_reset_priority();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        run_op(2, 32'h3, 32'h3, 1'b1, "dir_w2_max");
        run_op(32, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "dir_w32_wrap");
        test_random(8, 1000);
        test_random(2, 1000);
        test_random(32, 600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
